mem_addr_reg: RTL

//  Memory address register (MAR) and memory-access sequencer, directly downstream of addr_bus.
//  - Captures the address-bus output, or builds an address from data-bus bytes, then applies
//    6502-style adjustments: increment, indexed add with page-cross fix-up, zero-page wrap.
//  - Holds the address stable for the memory array and runs the enable/ack handshake.

---
 rtl/mem_addr_reg_pkg.sv | 24 ++
 rtl/mar_page_adder.sv | 11 +
 rtl/mem_addr_reg.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_addr_reg_pkg.sv
// Shared command/state codes and constants for the memory address register slice.
package mem_addr_reg_pkg;

    localparam int          MAR_ADDR_WIDTH = 16;
    localparam logic [15:0] RESET_VECTOR   = 16'hFFFC;

    typedef enum logic [2:0] {
        MAR_NOP      = 3'd0,
        MAR_LOAD_BUS = 3'd1,
        MAR_LOAD_LO  = 3'd2,
        MAR_LOAD_HI  = 3'd3,
        MAR_INC      = 3'd4,
        MAR_ADD_IDX  = 3'd5,
        MAR_ZP_IDX   = 3'd6,
        MAR_RSVD     = 3'd7
    } mar_cmd_e;

    typedef enum logic [1:0] {
        MAR_IDLE   = 2'd0,
        MAR_FIX_HI = 2'd1,
        MAR_MEM    = 2'd2
    } mar_state_e;

endpackage

// File: rtl/mar_page_adder.sv
// 8-bit adder returning carry and sum; serves both the index add and the high-byte fix-up.
module mar_page_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       carry,
    output logic [7:0] sum
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mem_addr_reg.sv
// Memory address register with 6502-style address adjustments and a memory enable/ack sequencer.
module mem_addr_reg
    import mem_addr_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = MAR_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = RESET_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] bus_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] idx_in,
    input  logic [2:0]            cmd,
    input  logic                  cmd_valid,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  page_cross
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    mar_state_e            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic                  busy_q;
    logic                  page_cross_q;
    logic                  pend_vld;
    logic                  pend_we;

    logic                  lo_carry;
    logic [7:0]            lo_sum;
    logic                  hi_carry_unused;
    logic [7:0]            hi_sum;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  fix_needed;
    logic                  req;

    mar_page_adder u_lo_add (
        .a     (addr_q[7:0]),
        .b     (idx_in),
        .carry (lo_carry),
        .sum   (lo_sum)
    );

    mar_page_adder u_hi_add (
        .a     (addr_q[15:8]),
        .b     (8'h01),
        .carry (hi_carry_unused),
        .sum   (hi_sum)
    );

    assign req = rd_req | wr_req;

    // Address the IDLE state would load this cycle, and whether a high-byte fix-up must follow.
    always_comb begin
        cmd_addr   = addr_q;
        fix_needed = 1'b0;
        if (cmd_valid) begin
            case (mar_cmd_e'(cmd))
                MAR_LOAD_BUS: cmd_addr = bus_in;
                MAR_LOAD_LO:  cmd_addr = {addr_q[15:8], data_in};
                MAR_LOAD_HI:  cmd_addr = {data_in, addr_q[7:0]};
                MAR_INC:      cmd_addr = addr_q + ADDR_ONE;
                MAR_ADD_IDX: begin
                    cmd_addr   = {addr_q[15:8], lo_sum};
                    fix_needed = lo_carry;
                end
                MAR_ZP_IDX:   cmd_addr = {8'h00, lo_sum};
                default:      cmd_addr = addr_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= MAR_IDLE;
            addr_q       <= RESET_ADDR;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            page_cross_q <= 1'b0;
            pend_vld     <= 1'b0;
            pend_we      <= 1'b0;
        end else begin
            page_cross_q <= 1'b0;
            case (state)
                MAR_IDLE: begin
                    addr_q <= cmd_addr;
                    if (fix_needed) begin
                        state        <= MAR_FIX_HI;
                        busy_q       <= 1'b1;
                        page_cross_q <= 1'b1;
                        pend_vld     <= req;
                        pend_we      <= wr_req;
                    end else if (req) begin
                        state    <= MAR_MEM;
                        mem_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        mem_we_q <= wr_req;
                    end
                end
                MAR_FIX_HI: begin
                    addr_q[15:8] <= hi_sum;
                    pend_vld     <= 1'b0;
                    if (pend_vld) begin
                        state    <= MAR_MEM;
                        mem_en_q <= 1'b1;
                        mem_we_q <= pend_we;
                    end else begin
                        state  <= MAR_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                MAR_MEM: begin
                    if (mem_ack) begin
                        state    <= MAR_IDLE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state    <= MAR_IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out   = addr_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign page_cross = page_cross_q;

endmodule
